// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store initiator onto a word memory (optional LSU_SIGNED_LOAD_EN)
module load_store_unit #(
    parameter int DATA_W  = 32,
    parameter int CELL_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_control_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int SHW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic              accept;
    logic              misaligned;
    logic              sub_word;
    logic [1:0]        op_size;
    logic              op_signed;
    logic [1:0]        op_lane;
    logic              fault_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] merged;
    logic [SHW-1:0]    shamt;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lane_mask;
    logic              ext_bit;
    logic              unused_bits;

    // Held in reset the unit must not look ready, so the pipeline cannot hand it work.
    assign req_ready         = !reset && (state == S_IDLE || state == S_RESP);
    assign accept            = req_valid && req_ready;
    assign misaligned        = (req_size == 2'd1 && req_addr[0]) ||
                               (req_size[1] && req_addr[1:0] != 2'b00);
    assign sub_word          = !req_size[1];

    assign mem_control_write = (state == S_WR) || (state == S_RMW_WR);
    assign resp_valid        = (state == S_RESP);
    assign resp_fault        = fault_q && (state == S_RESP);
    assign resp_rdata        = rdata_q;
    assign mem_address       = addr_q;
    assign mem_write_data    = wdata_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a new request can start from IDLE or straight out of RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (misaligned)     state_nxt = S_RESP;
                    else if (!req_write) state_nxt = S_RD;
                    else if (sub_word)  state_nxt = S_RMW_RD;
                    else                state_nxt = S_WR;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RD, S_WR, S_RMW_WR: state_nxt = S_RESP;
            S_RMW_RD:             state_nxt = S_RMW_WR;
            default:              state_nxt = S_IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        shamt     = '0;
        lane_mask = '0;
        ext_bit   = 1'b0;
        if (op_size == 2'd0) begin
            shamt     = SHW'({op_lane, 3'b000});
            lane_mask = {{(DATA_W-8){1'b0}}, 8'hFF} << shamt;
        end else begin
            shamt     = SHW'({op_lane[1], 4'b0000});
            lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << shamt;
        end
        shifted = mem_read_data >> shamt;
`ifdef LSU_SIGNED_LOAD_EN
        ext_bit = op_signed && ((op_size == 2'd0) ? shifted[7] : shifted[15]);
`endif
        case (op_size)
            2'd0:    load_value = {{(DATA_W-8){ext_bit}}, shifted[7:0]};
            2'd1:    load_value = {{(DATA_W-16){ext_bit}}, shifted[15:0]};
            default: load_value = mem_read_data;
        endcase
        // wdata_q still holds the right-aligned store data during RMW_RD.
        merged = (mem_read_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

`ifdef LSU_SIGNED_LOAD_EN
    assign unused_bits = ^req_addr[DATA_W-1:CELL_AW+2];
`else
    assign unused_bits = ^{req_addr[DATA_W-1:CELL_AW+2], op_signed};
`endif

    // Request latch and memory-side datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_size   <= '0;
            op_signed <= 1'b0;
            op_lane   <= '0;
            fault_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else if (accept) begin
            op_size   <= req_size;
            op_signed <= req_signed;
            op_lane   <= req_addr[1:0];
            fault_q   <= misaligned;
            rdata_q   <= '0;
            if (!misaligned) begin
                addr_q  <= {{(DATA_W-CELL_AW){1'b0}}, req_addr[CELL_AW+1:2]};
                wdata_q <= req_wdata;
            end
        end else if (state == S_RD) begin
            rdata_q <= load_value;
        end else if (state == S_RMW_RD) begin
            wdata_q <= merged;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_control_write;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];
    int          wr_cnt   = 0;
    int          resp_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_W(32), .CELL_AW(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_size          (req_size),
        .req_signed        (req_signed),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_fault        (resp_fault),
        .mem_address       (mem_address),
        .mem_write_data    (mem_write_data),
        .mem_control_write (mem_control_write),
        .mem_read_data     (mem_read_data)
    );

    assign mem_read_data = mem[mem_address[7:0]];

    always @(posedge clk) begin
        if (mem_control_write) begin
            mem[mem_address[7:0]] <= mem_write_data;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_address;
        end
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic flt);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd  = resp_rdata;
        flt = resp_fault;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_control_write !== 1'b0 ||
            mem_address !== 32'h0 || resp_rdata !== 32'h0 || resp_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rv=%b wr=%b addr=%h rd=%h flt=%b, required all 0",
                     req_ready, resp_valid, mem_control_write, mem_address, resp_rdata, resp_fault);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic flt; int w0;
        w0 = wr_cnt;
        run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, flt);
        checks++;
        if (lat !== 2 || flt !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL word_store_resp: lat=%0d flt=%b rd=%h required 2/0/0", lat, flt, rd);
        end
        checks++;
        if (wr_cnt - w0 !== 1 || last_wr_addr !== 32'd4 || mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_store_mem: writes=%0d addr=%h cell=%h required 1/4/deadbeef",
                     wr_cnt - w0, last_wr_addr, mem[4]);
        end
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, flt);
        checks++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || flt !== 1'b0) begin
            errors++;
            $display("FAIL word_load: lat=%0d rd=%h flt=%b required 2/deadbeef/0", lat, rd, flt);
        end
    endtask

    task automatic test_byte_store();
        int lat; logic [31:0] rd; logic flt; int w0;
        w0 = wr_cnt;
        run_req(1'b1, 2'd0, 1'b0, 32'h06, 32'h123456AA, lat, rd, flt);
        checks++;
        if (lat !== 3 || flt !== 1'b0) begin
            errors++;
            $display("FAIL byte_store_lat: lat=%0d flt=%b required 3/0", lat, flt);
        end
        checks++;
        if (mem[1] !== 32'h11AA3344 || wr_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL byte_store_mem: cell=%h writes=%0d required 11aa3344/1", mem[1], wr_cnt - w0);
        end
        w0 = wr_cnt;
        run_req(1'b1, 2'd1, 1'b0, 32'h06, 32'hFFFFBEEF, lat, rd, flt);
        checks++;
        if (lat !== 3 || mem[1] !== 32'hBEEF3344 || wr_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL half_store: lat=%0d cell=%h writes=%0d required 3/beef3344/1",
                     lat, mem[1], wr_cnt - w0);
        end
    endtask

    task automatic test_signed_load();
        int lat; logic [31:0] rd; logic flt;
        logic [31:0] exp_b, exp_h;
`ifdef LSU_SIGNED_LOAD_EN
        exp_b = 32'hFFFFFF80;
        exp_h = 32'hFFFFF080;
`else
        exp_b = 32'h00000080;
        exp_h = 32'h0000F080;
`endif
        run_req(1'b0, 2'd0, 1'b1, 32'h08, 32'h0, lat, rd, flt);
        checks++;
        if (lat !== 2 || rd !== exp_b) begin
            errors++;
            $display("FAIL byte_load_signed: lat=%0d rd=%h required 2/%h", lat, rd, exp_b);
        end
        run_req(1'b0, 2'd1, 1'b1, 32'h08, 32'h0, lat, rd, flt);
        checks++;
        if (rd !== exp_h) begin
            errors++;
            $display("FAIL half_load_signed: rd=%h required %h", rd, exp_h);
        end
        run_req(1'b0, 2'd0, 1'b0, 32'h09, 32'h0, lat, rd, flt);
        checks++;
        if (rd !== 32'h000000F0) begin
            errors++;
            $display("FAIL byte_load_lane1: rd=%h required 000000f0", rd);
        end
        run_req(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0, lat, rd, flt);
        checks++;
        if (rd !== 32'h00001234) begin
            errors++;
            $display("FAIL half_load_upper: rd=%h required 00001234", rd);
        end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic flt; int w0;
        w0 = wr_cnt;
        run_req(1'b0, 2'd2, 1'b0, 32'h0A, 32'h0, lat, rd, flt);
        checks++;
        if (lat !== 1 || flt !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL misaligned_load: lat=%0d flt=%b rd=%h required 1/1/0", lat, flt, rd);
        end
        run_req(1'b1, 2'd1, 1'b0, 32'h03, 32'h0000FFFF, lat, rd, flt);
        checks++;
        if (lat !== 1 || flt !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_store: lat=%0d flt=%b required 1/1", lat, flt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_cnt - w0 !== 0 || mem[0] !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL misaligned_nowrite: writes=%0d cell0=%h required 0/cafe0001", wr_cnt - w0, mem[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [3];
        int gap;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_signed = 1'b0;
        req_addr  = 32'h10;
        @(posedge clk); #1;
        req_addr = 32'h04;
        @(posedge clk); #1;
        got[0] = resp_valid ? resp_rdata : 32'hXXXXXXXX;
        @(posedge clk); #1;
        gap = resp_valid ? 1 : 0;
        req_addr = 32'h400;
        @(posedge clk); #1;
        got[1] = resp_valid ? resp_rdata : 32'hXXXXXXXX;
        @(posedge clk); #1;
        gap += resp_valid ? 1 : 0;
        req_valid = 1'b0;
        @(posedge clk); #1;
        got[2] = resp_valid ? resp_rdata : 32'hXXXXXXXX;
        checks++;
        if (got[0] !== 32'hDEADBEEF || got[1] !== 32'hBEEF3344 || gap !== 0) begin
            errors++;
            $display("FAIL back_to_back: r0=%h r1=%h gaps_with_resp=%0d required deadbeef/beef3344/0",
                     got[0], got[1], gap);
        end
        checks++;
        if (got[2] !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL wrap_load: rd=%h required cafe0001", got[2]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_rmw();
        int w0, r0;
        w0 = wr_cnt;
        r0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h0D;
        req_wdata = 32'h000000CC;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_address !== 32'd3 || mem_control_write !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmw_rd_phase: addr=%h wr=%b ready=%b required 3/0/0",
                     mem_address, mem_control_write, req_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_address !== 32'h0 || mem_write_data !== 32'h0 || mem_control_write !== 1'b0 ||
            resp_valid !== 1'b0 || resp_fault !== 1'b0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_rmw_outputs: addr=%h wd=%h wr=%b rv=%b required all 0",
                     mem_address, mem_write_data, mem_control_write, resp_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_rmw_ready: got %b required 1", req_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem[3] !== 32'h55667788 || wr_cnt - w0 !== 0 || resp_cnt - r0 !== 0) begin
            errors++;
            $display("FAIL reset_mid_rmw_mem: cell3=%h writes=%0d resps=%0d required 55667788/0/0",
                     mem[3], wr_cnt - w0, resp_cnt - r0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[0] <= 32'hCAFE0001;
        mem[1] <= 32'h11223344;
        mem[2] <= 32'h0000F080;
        mem[3] <= 32'h55667788;
        test_reset();
        test_word();
        test_byte_store();
        mem[3] <= 32'h12345678;
        @(posedge clk);
        test_signed_load();
        mem[3] <= 32'h55667788;
        @(posedge clk);
        test_misaligned();
        test_back_to_back();
        test_reset_mid_rmw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-addressed data memory: takes load/store requests from the pipeline MEM stage and drives the memory's address / write_data / control_write / read_data interface.
- Converts byte-addressed, byte/half/word accesses into word accesses.
- Sub-word stores are done as read-modify-write, because the memory writes whole words only.
- Provides a valid/ready request handshake and a one-cycle response pulse, so the pipeline can stall on it.

Parameters:
- DATA_W, 32, data word width; fixed by the memory cell width.
- CELL_AW, 8, word-index width; the memory holds 2**CELL_AW cells.

Ports:
- clk  input  1  clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_signed  input  1  sign-extend sub-word loads (see Optional Feature).
- req_addr  input  DATA_W  byte address.
- req_wdata  input  DATA_W  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_W  load result, right-aligned; 0 for stores.
- resp_fault  output  1  misaligned access; qualified by resp_valid.
- mem_address  output  DATA_W  word index, zero-extended.
- mem_write_data  output  DATA_W  word to write.
- mem_control_write  output  1  1 = write cycle, 0 = read.
- mem_read_data  input  DATA_W  combinational read word.

Behaviour:
- All outputs are registered or decoded directly from the state register; no combinational path from req_* to mem_*.
- Reset (async, any state): state to IDLE. req_ready=1 once reset deasserts. All other outputs are 0, including mem_control_write, so no spurious write is issued.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- Accept condition: req_valid && req_ready at a rising edge. req_ready=1 only in IDLE and RESP; accepting in RESP allows back-to-back requests.
- Word index: req_addr[CELL_AW+1:2], zero-extended onto mem_address. Upper address bits are ignored, so indices wrap modulo 2**CELL_AW.
- Misalignment check: half with addr[0]=1, or word with addr[1:0]!=0.
  - Goes directly to RESP with resp_fault=1 and resp_rdata=0.
  - No memory cycle is issued; mem_control_write stays 0.
- Word load: accept -> RD -> RESP.
  - RD: mem_control_write=0.
  - mem_read_data is captured at the end of RD.
- Sub-word load: same path as word load. Byte lane is selected by addr[1:0], half lane by addr[1]. Little-endian: byte 0 = bits 7:0. Result is right-aligned.
- Word store: accept -> WR -> RESP. WR: mem_control_write=1, mem_write_data=req_wdata.
- Sub-word store: accept -> RMW_RD -> RMW_WR -> RESP.
  - RMW_RD: captures the old word.
  - RMW_WR: mem_control_write=1 with the merged word; only the addressed byte/half lanes are replaced by req_wdata[7:0] / [15:0].
  - mem_address is held constant across both cycles.
- Latency, counted from the accept edge; resp_valid is high in the cycle starting at:
  - 1 edge for faults;
  - 2 edges for loads and word stores;
  - 3 edges for sub-word stores.
- RESP:
  - resp_valid=1 for exactly one cycle; there is no response back-pressure.
  - Accept in RESP: go to the next operation's first state.
  - Otherwise: go to IDLE.
- Request fields are latched at accept; later changes to req_* are ignored until the next accept.
- mem_control_write is 1 only in WR and RMW_WR. mem_address and mem_write_data hold their last values while idle.
- Reset asserted mid-RMW: the write cycle is aborted and memory is untouched if reset arrives before RMW_WR. resp_valid is never issued for the aborted request.

Optional Feature:
- Macro: LSU_SIGNED_LOAD_EN.
- Defined: byte/half loads with req_signed=1 are sign-extended from bit 7/15. Loads with req_signed=0 are zero-extended.
- Undefined: req_signed is ignored and all sub-word loads are zero-extended. Port still present.

Test Plan:
- Word store then word load: store 0xDEADBEEF to addr 0x10, then load addr 0x10.
  - Store: mem_control_write=1 for exactly one cycle with mem_address=4.
  - Load: resp_rdata=0xDEADBEEF, resp_valid 2 edges after accept.
- Byte store RMW: cell 1 holds 0x11223344; store byte 0xAA to addr 0x06.
  - Cell 1 becomes 0x11AA3344.
  - Response arrives 3 edges after accept; exactly one write cycle.
- Signed load: cell 2 holds 0x0000F080; byte load of addr 0x08.
  - With req_signed=1: 0xFFFFFF80 when LSU_SIGNED_LOAD_EN is defined, 0x00000080 when it is not.
  - Half load of addr 0x08 with req_signed=1 (LSU_SIGNED_LOAD_EN defined): 0xFFFFF080.
- Misaligned requests: word load of 0x0A, or half store of 0x03.
  - resp_valid and resp_fault both 1, 1 edge after accept.
  - mem_control_write never asserts; memory contents are unchanged.
- Back-to-back and wrap:
  - req_valid held with 3 word loads: accepted in RESP cycles; responses every 2 cycles.
  - Load of addr 0x400 (CELL_AW=8) reads cell 0.
- Reset mid-RMW: assert reset during RMW_RD of a byte store.
  - Outputs go to 0 immediately; the cell is unchanged; no resp_valid.
  - req_ready=1 after reset releases.
